bundle_sequencer: RTL and testbench
===================================

BUNDLE_SEQUENCER -- requirements
Module: bundle_sequencer

Interface
REQ-001 SHALL have parameters: ELEMENT_WIDTH, default 64, adder/memory word width; NUM_ELEMENTS, default 16, words per hypervector; MAX_VECTORS, default 16, maximum vectors per bundle; ADDR_WIDTH, default 8, memory word-address width.
REQ-002 SHALL run on one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-003 Ports (name direction width meaning):
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
start  in  1  request a bundle operation
num_vectors  in  $clog2(MAX_VECTORS+1)  vector count K
src_base  in  ADDR_WIDTH  address of vector 0, word 0
dst_base  in  ADDR_WIDTH  address of result word 0
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
error  out  1  K<2 or K>MAX_VECTORS on last start, valid with done
overflow  out  1  sticky: any result word overflowed
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_WIDTH  read address
rd_data  in  ELEMENT_WIDTH  read data, 1-cycle latency
wr_en  out  1  memory write strobe
wr_addr  out  ADDR_WIDTH  write address
wr_data  out  ELEMENT_WIDTH  write data
add_valid  out  1  adder valid
add_bundle_loop  out  1  adder accumulate select
add_elem_A  out  ELEMENT_WIDTH  adder operand A
add_elem_B  out  ELEMENT_WIDTH  adder operand B
add_elem_out  in  ELEMENT_WIDTH  registered adder sum
add_overflow  in  1  adder overflow flag

Function
REQ-004 States SHALL be IDLE, FETCH, LAST, WRITE, FINISH.
REQ-005 In IDLE, start=1 SHALL latch num_vectors, src_base, dst_base, clear overflow and error, and go to FETCH (element e=0, vector v=0); start outside IDLE SHALL be ignored.
REQ-006 If latched K<2 or K>MAX_VECTORS, the FSM SHALL go IDLE->FINISH directly, set error=1, and issue no rd_en/wr_en.
REQ-007 FETCH SHALL last K cycles, asserting rd_en with rd_addr = src_base + v*NUM_ELEMENTS + e (mod 2^ADDR_WIDTH), v=0..K-1; then go to LAST.
REQ-008 Cycle after the vector-0 read: rd_data SHALL be captured in an internal hold register; no add_valid.
REQ-009 Cycle after the vector-1 read: add_valid=1, add_bundle_loop=0, add_elem_A=rd_data, add_elem_B=hold.
REQ-010 Cycle after each vector-v read, v>=2: add_valid=1, add_bundle_loop=1, add_elem_A=rd_data; add_elem_B=0.
REQ-011 LAST SHALL last 1 cycle (final add issued, no read), then go to WRITE.
REQ-012 WRITE SHALL last 1 cycle: wr_en=1, wr_addr=dst_base+e (mod 2^ADDR_WIDTH), wr_data=add_elem_out; overflow |= add_overflow.
REQ-013 After WRITE: if e<NUM_ELEMENTS-1, e++, v=0, go to FETCH; else go to FINISH.
REQ-014 FINISH SHALL assert done for exactly one cycle, then go to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Latency: start accepted at edge 0, done=1 in cycle 1+NUM_ELEMENTS*(K+2); error path: done in cycle 1.
REQ-017 rd_en, wr_en, add_valid SHALL never be high in IDLE or FINISH; rd_en and wr_en never high in the same cycle.
REQ-018 overflow and error SHALL hold their values until the next accepted start.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE, e=v=0, hold=0, latched fields 0, and all outputs 0 in the following cycle, including mid-operation; no further write SHALL issue.

Structure
REQ-020 State enum, state width, and default parameter constants SHALL reside in shared package bundle_pkg.
REQ-021 The address arithmetic of REQ-007/REQ-012 SHALL be one sub-module, bundle_addr_gen.
REQ-022 The adder SHALL be external; this block only drives and samples its ports.

Verification
REQ-023 K=2, NUM_ELEMENTS=16, src_base=0, dst_base=0x40, vec0 words=1, vec1 words=2 -> 16 writes of 3 to 0x40..0x4F, done in cycle 65, overflow=0.
REQ-024 K=4, words 10,20,30,40 per element -> every result 100; add_bundle_loop = 0,1,1 per element.
REQ-025 K=2, element 5 of both vectors = 0x7FFF_FFFF_FFFF_FFFF -> overflow=1 after element 5 write, still 1 at done.
REQ-026 K=1, then K=17 -> done in cycle 1, error=1, zero rd_en/wr_en.
REQ-027 src_base=0xF8, K=2 -> reads wrap past 0xFF to 0x00 onward; start re-asserted while busy -> ignored.
REQ-028 reset=1 during FETCH of element 3 -> outputs 0 next cycle, no further writes, new start works normally.

Source files
------------

// File: rtl/bundle_pkg.sv
// Shared definitions for the hypervector bundle sequencer: FSM state encoding
// and default sizing constants.
package bundle_pkg;

    localparam int DEF_ELEMENT_WIDTH = 64;
    localparam int DEF_NUM_ELEMENTS  = 16;
    localparam int DEF_MAX_VECTORS   = 16;
    localparam int DEF_ADDR_WIDTH    = 8;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAST   = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } bundle_state_e;

endpackage

// File: rtl/bundle_addr_gen.sv
// Memory address arithmetic for the bundle sequencer: source word of vector v,
// element e, and destination word of element e, all modulo 2^ADDR_WIDTH.
module bundle_addr_gen #(
    parameter int ADDR_WIDTH   = bundle_pkg::DEF_ADDR_WIDTH,
    parameter int NUM_ELEMENTS = bundle_pkg::DEF_NUM_ELEMENTS,
    parameter int VW           = 5,
    parameter int EW           = 4
) (
    input  logic [ADDR_WIDTH-1:0] src_base_i,
    input  logic [ADDR_WIDTH-1:0] dst_base_i,
    input  logic [VW-1:0]         vec_idx_i,
    input  logic [EW-1:0]         elem_idx_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o
);

    // Truncating every operand to the address width keeps the wrap-around exact.
    assign rd_addr_o = src_base_i
                     + ADDR_WIDTH'(vec_idx_i) * ADDR_WIDTH'(NUM_ELEMENTS)
                     + ADDR_WIDTH'(elem_idx_i);
    assign wr_addr_o = dst_base_i + ADDR_WIDTH'(elem_idx_i);

endmodule

// File: rtl/bundle_sequencer.sv
// Bundles K hypervectors element by element: reads each vector's word, drives
// an external adder to accumulate them, and writes the sum back to memory.
module bundle_sequencer
    import bundle_pkg::*;
#(
    parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int NUM_ELEMENTS  = DEF_NUM_ELEMENTS,
    parameter int MAX_VECTORS   = DEF_MAX_VECTORS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [$clog2(MAX_VECTORS+1)-1:0] num_vectors,
    input  logic [ADDR_WIDTH-1:0]            src_base,
    input  logic [ADDR_WIDTH-1:0]            dst_base,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             overflow,
    output logic                             rd_en,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [ELEMENT_WIDTH-1:0]         rd_data,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [ELEMENT_WIDTH-1:0]         wr_data,
    output logic                             add_valid,
    output logic                             add_bundle_loop,
    output logic [ELEMENT_WIDTH-1:0]         add_elem_A,
    output logic [ELEMENT_WIDTH-1:0]         add_elem_B,
    input  logic [ELEMENT_WIDTH-1:0]         add_elem_out,
    input  logic                             add_overflow
);

    localparam int KW = $clog2(MAX_VECTORS + 1);
    localparam int EW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [EW-1:0] E_LAST = EW'(NUM_ELEMENTS - 1);

    bundle_state_e           state_q;
    logic [KW-1:0]           k_q;
    logic [ADDR_WIDTH-1:0]   src_q;
    logic [ADDR_WIDTH-1:0]   dst_q;
    logic [KW-1:0]           v_q;
    logic [EW-1:0]           e_q;
    logic                    prev_rd_q;
    logic [KW-1:0]           prev_v_q;
    logic [ELEMENT_WIDTH-1:0] hold_q;
    logic                    ovf_q;
    logic                    err_q;

    logic                    k_bad;
    logic [ADDR_WIDTH-1:0]   rd_addr_raw;
    logic [ADDR_WIDTH-1:0]   wr_addr_raw;

    assign k_bad = (num_vectors < KW'(2)) || (num_vectors > KW'(MAX_VECTORS));

    bundle_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .VW           (KW),
        .EW           (EW)
    ) u_addr_gen (
        .src_base_i (src_q),
        .dst_base_i (dst_q),
        .vec_idx_i  (v_q),
        .elem_idx_i (e_q),
        .rd_addr_o  (rd_addr_raw),
        .wr_addr_o  (wr_addr_raw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            v_q       <= '0;
            e_q       <= '0;
            prev_rd_q <= 1'b0;
            prev_v_q  <= '0;
            hold_q    <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Read data returns one cycle later; remember which vector it belongs to.
            prev_rd_q <= (state_q == FETCH);
            prev_v_q  <= v_q;
            if (prev_rd_q && (prev_v_q == '0)) begin
                hold_q <= rd_data;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_q   <= num_vectors;
                        src_q <= src_base;
                        dst_q <= dst_base;
                        ovf_q <= 1'b0;
                        v_q   <= '0;
                        e_q   <= '0;
                        err_q <= k_bad;
                        state_q <= k_bad ? FINISH : FETCH;
                    end
                end
                FETCH: begin
                    if (v_q == k_q - KW'(1)) begin
                        v_q     <= '0;
                        state_q <= LAST;
                    end else begin
                        v_q <= v_q + KW'(1);
                    end
                end
                LAST: state_q <= WRITE;
                WRITE: begin
                    ovf_q <= ovf_q | add_overflow;
                    if (e_q == E_LAST) begin
                        state_q <= FINISH;
                    end else begin
                        e_q     <= e_q + EW'(1);
                        state_q <= FETCH;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign error    = err_q;
    assign overflow = ovf_q;
    assign rd_en    = (state_q == FETCH);
    assign wr_en    = (state_q == WRITE);

    // Vector 1 starts a fresh sum with the held vector-0 word; later vectors accumulate.
    assign add_valid       = prev_rd_q && (prev_v_q != '0);
    assign add_bundle_loop = add_valid && (prev_v_q != KW'(1));
    assign add_elem_A      = add_valid ? rd_data : '0;
    assign add_elem_B      = (add_valid && !add_bundle_loop) ? hold_q : '0;

    assign rd_addr = rd_en ? rd_addr_raw : '0;
    assign wr_addr = wr_en ? wr_addr_raw : '0;
    assign wr_data = wr_en ? add_elem_out : '0;

endmodule

// File: tb/tb_bundle_sequencer.sv
// Scoreboard bench for bundle_sequencer with a behavioural memory, adder and
// bundle model.
module tb_bundle_sequencer;

    localparam int W  = 64;
    localparam int N  = 16;
    localparam int MV = 16;
    localparam int AW = 8;
    localparam int KW = $clog2(MV + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] num_vectors;
    logic [AW-1:0] src_base, dst_base;
    logic          busy, done, error, overflow;
    logic          rd_en, wr_en, add_valid, add_bundle_loop;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  rd_data = '0;
    logic [W-1:0]  wr_data, add_elem_A, add_elem_B;
    logic [W-1:0]  acc = '0;
    logic          aovf = 1'b0;

    always #5 clk = ~clk;

    bundle_sequencer #(
        .ELEMENT_WIDTH (W),
        .NUM_ELEMENTS  (N),
        .MAX_VECTORS   (MV),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_vectors     (num_vectors),
        .src_base        (src_base),
        .dst_base        (dst_base),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .overflow        (overflow),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .add_valid       (add_valid),
        .add_bundle_loop (add_bundle_loop),
        .add_elem_A      (add_elem_A),
        .add_elem_B      (add_elem_B),
        .add_elem_out    (acc),
        .add_overflow    (aovf)
    );

    // ---------------- memory and adder responders ----------------
    logic [W-1:0] mem [0:255];

    function automatic logic sovf(logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(posedge clk) begin
        if (add_valid) begin
            if (!add_bundle_loop) begin
                acc  <= add_elem_A + add_elem_B;
                aovf <= sovf(add_elem_A, add_elem_B);
            end else begin
                acc  <= acc + add_elem_A;
                aovf <= aovf | sovf(acc, add_elem_A);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          ovf;
    } wr_t;

    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic          exp_loop_q[$];
    int            compared = 0;
    int            mismatched = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    logic          ovf_pend = 1'b0;
    logic          ovf_exp = 1'b0;
    wr_t           wr_item;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ovf_pend) begin
            check("overflow_after_write", 64'(overflow), 64'(ovf_exp));
            ovf_pend = 1'b0;
        end
        if (rd_en) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(rd_en), 64'(0));
            else check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
        end
        if (wr_en) begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) begin
                check("wr_unexpected", 64'(wr_en), 64'(0));
            end else begin
                wr_item = exp_wr_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(wr_item.addr));
                check("wr_data", wr_data, wr_item.data);
                ovf_pend = 1'b1;
                ovf_exp  = wr_item.ovf;
            end
        end
        if (add_valid) begin
            if (exp_loop_q.size() == 0) check("add_unexpected", 64'(add_valid), 64'(0));
            else check("add_bundle_loop", 64'(add_bundle_loop), 64'(exp_loop_q.pop_front()));
        end
        check("rd_wr_exclusive", 64'(rd_en & wr_en), 64'(0));
        check("strobe_idle_finish", 64'((rd_en | wr_en | add_valid) & (~busy | done)), 64'(0));
    end

    // ---------------- reference model ----------------
    // Bundle result of element e is the wrapping sum over v of mem[src + v*N + e];
    // overflow is any signed overflow along that running sum.
    task automatic model_op(input int k, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input int n_wr, input int n_rd, input int n_add, output logic cum);
        int reads = 0;
        int adds = 0;
        logic [AW-1:0] a;
        logic [W-1:0] s, w;
        logic eo;
        cum = 1'b0;
        for (int e = 0; e < N; e++) begin
            s = '0;
            eo = 1'b0;
            for (int v = 0; v < k; v++) begin
                a = src + AW'(v * N + e);
                if (reads < n_rd) exp_rd_q.push_back(a);
                reads++;
                w = mem[a];
                if (v > 0) begin
                    if (adds < n_add) exp_loop_q.push_back(v >= 2);
                    adds++;
                    eo = eo | sovf(s, w);
                end
                s = s + w;
            end
            cum = cum | eo;
            if (e < n_wr) exp_wr_q.push_back('{addr: dst + AW'(e), data: s, ovf: cum});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_zero(string tag);
        check({tag, "_ctrl"}, 64'({busy, done, error, overflow, rd_en, wr_en, add_valid, add_bundle_loop}), 64'(0));
        check({tag, "_addrs"}, 64'({rd_addr, wr_addr}), 64'(0));
        check({tag, "_wr_data"}, wr_data, '0);
        check({tag, "_add_ops"}, add_elem_A | add_elem_B, '0);
    endtask

    task automatic issue_start(input int k, input logic [AW-1:0] src, input logic [AW-1:0] dst);
        @(negedge clk);
        start       = 1'b1;
        num_vectors = KW'(k);
        src_base    = src;
        dst_base    = dst;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [AW-1:0] src, input logic [AW-1:0] dst, input bit poke);
        logic exp_ovf;
        bit   bad;
        int   cyc, rd0, wr0, lat;
        bad = (k < 2) || (k > MV);
        exp_ovf = 1'b0;
        if (!bad) model_op(k, src, dst, N, k * N, (k - 1) * N, exp_ovf);
        lat = bad ? 1 : 1 + N * (k + 2);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue_start(k, src, dst);
        cyc = 1;
        check("busy_after_start", 64'(busy), 64'(1));
        while (!done && cyc < 2000) begin
            if (poke && cyc >= 5 && cyc < 10) begin
                start = 1'b1;
                num_vectors = KW'(3);
                src_base = ~src;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 64'(done), 64'(1));
        check("done_latency", 64'(cyc), 64'(lat));
        check("error_at_done", 64'(error), 64'(bad));
        check("overflow_at_done", 64'(overflow), 64'(exp_ovf));
        if (bad) begin
            check("err_no_reads", 64'(rd_cnt - rd0), 64'(0));
            check("err_no_writes", 64'(wr_cnt - wr0), 64'(0));
        end else begin
            check("write_count", 64'(wr_cnt - wr0), 64'(N));
        end
        check("queues_drained", 64'(exp_wr_q.size() + exp_rd_q.size() + exp_loop_q.size()), 64'(0));
        @(negedge clk);
        check("done_one_cycle", 64'({done, busy}), 64'(0));
        check("error_holds", 64'(error), 64'(bad));
        check("overflow_holds", 64'(overflow), 64'(exp_ovf));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic dummy;
        int   wr0;
        reset = 1'b1;
        start = 1'b0;
        num_vectors = '0;
        src_base = '0;
        dst_base = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;

        // Two-vector sum of constants.
        for (int i = 0; i < 16; i++) begin
            mem[i] = 64'd1;
            mem[16 + i] = 64'd2;
        end
        run_op(2, 8'h00, 8'h40, 1'b0);

        // Four vectors: first add starts fresh, the rest accumulate.
        for (int v = 0; v < 4; v++)
            for (int e = 0; e < N; e++) mem[8'h80 + v * N + e] = 64'(10 * (v + 1));
        run_op(4, 8'h80, 8'h10, 1'b0);

        // Signed overflow only in element 5.
        for (int i = 0; i < 32; i++) mem[i] = 64'($urandom_range(0, 1000));
        mem[5]  = 64'h7FFF_FFFF_FFFF_FFFF;
        mem[21] = 64'h7FFF_FFFF_FFFF_FFFF;
        run_op(2, 8'h00, 8'h60, 1'b0);

        // Illegal vector counts.
        run_op(1, 8'h00, 8'h20, 1'b0);
        run_op(17, 8'h00, 8'h20, 1'b0);
        run_op(0, 8'h10, 8'h20, 1'b0);

        // Source window wrapping past the top of memory, with start pokes while busy.
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        run_op(2, 8'hF8, 8'h30, 1'b1);

        // Randomized operations.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 5000));
            run_op($urandom_range(2, MV), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of element 3 of a K=3 bundle.
        model_op(3, 8'h20, 8'hA0, 3, 11, 6, dummy);
        wr0 = wr_cnt;
        issue_start(3, 8'h20, 8'hA0);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_reset_writes", 64'(wr_cnt - wr0), 64'(3));
        check("mid_reset_queues", 64'(exp_wr_q.size() + exp_rd_q.size() + exp_loop_q.size()), 64'(0));
        run_op(3, 8'h20, 8'hA0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
